// File: rtl/uart_tx.sv
// Byte-wide async serial transmitter (start, 8 data LSB-first, optional even parity, STOP_BITS stops)
// with a one-byte hold buffer for gapless back-to-back frames. Define UART_TX_PARITY_EN for parity.
module uart_tx #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned DW  = 8;
  localparam int unsigned BCW = 3;
  localparam int unsigned SCW = 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DW - 1);
  localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t         state, state_n;
  logic [DW-1:0]  shifter, shifter_n;
  logic [BCW-1:0] bitcnt, bitcnt_n;
  logic [SCW-1:0] stopcnt, stopcnt_n;
  logic [DW-1:0]  hold_data, hold_data_n;
  logic           hold_valid, hold_valid_n;
  logic           tx_n;
  logic           busy_n;
  logic           load;
`ifdef UART_TX_PARITY_EN
  logic           par, par_n;
`endif

  // State and datapath registers; tx idles high and is forced high by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shifter    <= '0;
      bitcnt     <= '0;
      stopcnt    <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      tx         <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shifter    <= shifter_n;
      bitcnt     <= bitcnt_n;
      stopcnt    <= stopcnt_n;
      hold_data  <= hold_data_n;
      hold_valid <= hold_valid_n;
      tx         <= tx_n;
      in_ready   <= !hold_valid_n;
      busy       <= busy_n;
`ifdef UART_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

  // Next-state: hold buffer every cycle, frame FSM only on baud ticks.
  always_comb begin
    state_n      = state;
    shifter_n    = shifter;
    bitcnt_n     = bitcnt;
    stopcnt_n    = stopcnt;
    hold_data_n  = hold_data;
    hold_valid_n = hold_valid;
    tx_n         = tx;
    load         = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n        = par;
`endif

    if (in_valid && !hold_valid) begin
      hold_data_n  = in_data;
      hold_valid_n = 1'b1;
    end

    if (baud_tick) begin
      case (state)
        IDLE: load = hold_valid;
        START: begin
          tx_n      = shifter[0];
          shifter_n = shifter >> 1;
          bitcnt_n  = '0;
          state_n   = DATA;
        end
        DATA: begin
          if (bitcnt != BIT_LAST) begin
            tx_n      = shifter[0];
            shifter_n = shifter >> 1;
            bitcnt_n  = bitcnt + BCW'(1);
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_n    = par;
            state_n = PARITY;
`else
            tx_n      = 1'b1;
            stopcnt_n = '0;
            state_n   = STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_n      = 1'b1;
          stopcnt_n = '0;
          state_n   = STOP;
        end
`endif
        STOP: begin
          if (stopcnt != STOP_LAST) begin
            stopcnt_n = stopcnt + SCW'(1);
          end else if (hold_valid) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Load never coincides with an accept: it needs a full buffer.
    if (load) begin
      shifter_n    = hold_data;
      hold_valid_n = 1'b0;
      tx_n         = 1'b0;
      state_n      = START;
`ifdef UART_TX_PARITY_EN
      par_n        = ^hold_data;
`endif
    end

    busy_n = (state_n != IDLE) || hold_valid_n;
  end

endmodule
